// File: rtl/joint_histogram_reader.sv
// Joint-histogram bin capture buffer with frame statistics
// and random-access readback for the downstream classifier.
module joint_histogram_reader #(
    parameter int NUM_BINS = 512,
    parameter int COUNT_W  = 16,
    parameter int ADDR_W   = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [COUNT_W-1:0]        din_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    input  logic                      clear_i,
    input  logic                      rd_en_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    output logic [COUNT_W-1:0]        rd_data_o,
    output logic                      rd_valid_o,
    output logic                      ready_o,
    output logic [COUNT_W+ADDR_W-1:0] total_o,
    output logic [ADDR_W-1:0]         peak_bin_o,
    output logic [COUNT_W-1:0]        peak_val_o,
    output logic                      len_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READY
    } state_t;

    localparam logic [ADDR_W:0] NB  = NUM_BINS[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    state_t                    r_state;
    logic [ADDR_W:0]           r_ptr;
    logic [COUNT_W+ADDR_W-1:0] r_total;
    logic [ADDR_W-1:0]         r_peak_bin;
    logic [COUNT_W-1:0]        r_peak_val;
    logic                      r_len_err;
    logic                      r_ready;
    logic [COUNT_W-1:0]        r_rd_data;
    logic                      r_rd_valid;
    logic [COUNT_W-1:0]        r_mem [0:NUM_BINS-1];

    logic                      w_accept;
    logic                      w_in_rng;
    logic                      w_store;
    logic                      w_drop;
    logic [ADDR_W:0]           w_cnt_nxt;

    // A beat is only considered while a frame is being gathered.
    assign w_accept  = valid_i && !clear_i && !rst_n && (r_state != READY);
    assign w_in_rng  = (r_ptr < NB);
    assign w_store   = w_accept && w_in_rng;
    assign w_drop    = w_accept && !w_in_rng;
    assign w_cnt_nxt = w_store ? (r_ptr + ONE) : r_ptr;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_ptr[ADDR_W-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_total    <= '0;
            r_peak_bin <= '0;
            r_peak_val <= '0;
            r_len_err  <= 1'b0;
            r_ready    <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (clear_i) begin
                r_state    <= IDLE;
                r_ptr      <= '0;
                r_total    <= '0;
                r_peak_bin <= '0;
                r_peak_val <= '0;
                r_len_err  <= 1'b0;
                r_ready    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, CAPTURE: begin
                        if (w_store) begin
                            r_ptr   <= w_cnt_nxt;
                            r_total <= r_total + {{ADDR_W{1'b0}}, din_i};
                            if (din_i > r_peak_val) begin
                                r_peak_val <= din_i;
                                r_peak_bin <= r_ptr[ADDR_W-1:0];
                            end
                        end
                        if (last_i) begin
                            r_state   <= READY;
                            r_ready   <= 1'b1;
                            r_len_err <= r_len_err || w_drop
                                         || (w_cnt_nxt != NB);
                        end else begin
                            if (w_drop) begin
                                r_len_err <= 1'b1;
                            end
                            if (valid_i) begin
                                r_state <= CAPTURE;
                            end
                        end
                    end
                    READY: begin
                        if (rd_en_i) begin
                            r_rd_valid <= 1'b1;
                            if ({1'b0, rd_addr_i} < NB) begin
                                r_rd_data <= r_mem[rd_addr_i];
                            end else begin
                                r_rd_data <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign ready_o    = r_ready;
    assign total_o    = r_total;
    assign peak_bin_o = r_peak_bin;
    assign peak_val_o = r_peak_val;
    assign len_err_o  = r_len_err;

endmodule

// File: tb/tb_joint_histogram_reader.sv
// Bench for joint_histogram_reader: frame table plus hand sequences,
// reads checked through an expected-data queue.
module tb_joint_histogram_reader;

    localparam int NB = 8;
    localparam int CW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] din_i;
    logic          valid_i;
    logic          last_i;
    logic          clear_i;
    logic          rd_en_i;
    logic [AW-1:0] rd_addr_i;
    logic [CW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          ready_o;
    logic [CW+AW-1:0] total_o;
    logic [AW-1:0] peak_bin_o;
    logic [CW-1:0] peak_val_o;
    logic          len_err_o;

    int tot = 0;
    int bad = 0;
    logic [CW-1:0] rq[$];

    joint_histogram_reader #(
        .NUM_BINS(NB),
        .COUNT_W (CW),
        .ADDR_W  (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_i     (din_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .clear_i   (clear_i),
        .rd_en_i   (rd_en_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .rd_valid_o(rd_valid_o),
        .ready_o   (ready_o),
        .total_o   (total_o),
        .peak_bin_o(peak_bin_o),
        .peak_val_o(peak_val_o),
        .len_err_o (len_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int base;
        int step;
        bit last_with;
        int e_total;
        int e_pbin;
        int e_pval;
        bit e_err;
        bit do_rd;
        int rd_addr;
        int e_rd;
    } frame_t;

    frame_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Read-data scoreboard: every rd_valid_o pops one expected value.
    always @(posedge clk) begin
        #2;
        if (rd_valid_o) begin
            tot++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got data %0d expected no read",
                         rd_data_o);
            end else begin
                logic [CW-1:0] e;
                e = rq.pop_front();
                if (rd_data_o != e) begin
                    bad++;
                    $display("FAIL rd_data: got %0d expected %0d",
                             rd_data_o, e);
                end
            end
        end
    end

    task automatic send_frame(input int n, input int base, input int step,
                              input bit last_with);
        for (int i = 0; i < n; i++) begin
            din_i   = CW'(base + step * i);
            valid_i = 1'b1;
            last_i  = last_with && (i == n - 1);
            tick();
        end
        valid_i = 1'b0;
        if (!(last_with && n > 0)) begin
            last_i = 1'b1;
            tick();
        end
        last_i = 1'b0;
    endtask

    task automatic do_read(input int addr, input int e);
        rd_en_i   = 1'b1;
        rd_addr_i = AW'(addr);
        rq.push_back(CW'(e));
        tick();
        rd_en_i   = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8, 1, 1, 1'b1, 36, 7, 8, 1'b0, 1'b1, 3, 4};
        tbl[1] = '{8, 5, 0, 1'b0, 40, 0, 5, 1'b0, 1'b1, 7, 5};
        tbl[2] = '{6, 10, 0, 1'b0, 60, 0, 10, 1'b1, 1'b1, 5, 10};
        tbl[3] = '{10, 1, 0, 1'b0, 8, 0, 1, 1'b1, 1'b1, 0, 1};
        tbl[4] = '{0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0};
        tbl[5] = '{8, 2, 3, 1'b1, 100, 7, 23, 1'b0, 1'b1, 4, 14};

        rst_n = 1'b1;
        din_i = '0;
        valid_i = 1'b0;
        last_i = 1'b0;
        clear_i = 1'b0;
        rd_en_i = 1'b0;
        rd_addr_i = '0;
        tick();
        tick();
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_total", int'(total_o), 0);
        chk("rst_peak", int'(peak_val_o), 0);
        chk("rst_err", int'(len_err_o), 0);
        chk("rst_rdv", int'(rd_valid_o), 0);
        rst_n = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            send_frame(tbl[k].n, tbl[k].base, tbl[k].step, tbl[k].last_with);
            chk($sformatf("f%0d_ready", k), int'(ready_o), 1);
            chk($sformatf("f%0d_total", k), int'(total_o), tbl[k].e_total);
            chk($sformatf("f%0d_pbin", k), int'(peak_bin_o), tbl[k].e_pbin);
            chk($sformatf("f%0d_pval", k), int'(peak_val_o), tbl[k].e_pval);
            chk($sformatf("f%0d_err", k), int'(len_err_o), int'(tbl[k].e_err));
            if (tbl[k].do_rd) begin
                do_read(tbl[k].rd_addr, tbl[k].e_rd);
            end
            do_clear();
            chk($sformatf("f%0d_clr_ready", k), int'(ready_o), 0);
            chk($sformatf("f%0d_clr_total", k), int'(total_o), 0);
        end

        // Beat offered while READY must not disturb buffer or stats.
        send_frame(10, 1, 0, 1'b0);
        din_i = 16'd99;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("ready_beat_total", int'(total_o), 8);
        chk("ready_beat_peak", int'(peak_val_o), 1);
        do_read(0, 1);
        rd_en_i = 1'b1;
        rd_addr_i = 3'd6;
        rq.push_back(16'd1);
        tick();
        rd_addr_i = 3'd7;
        rq.push_back(16'd1);
        tick();
        rd_en_i = 1'b0;
        tick();
        do_clear();

        // Read attempt outside READY produces nothing.
        rd_en_i = 1'b1;
        rd_addr_i = 3'd1;
        tick();
        rd_en_i = 1'b0;
        chk("idle_rd_valid", int'(rd_valid_o), 0);

        // Reset in the middle of a capture.
        for (int i = 0; i < 4; i++) begin
            din_i = CW'(20 + i);
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("mid_rst_total", int'(total_o), 0);
        chk("mid_rst_pval", int'(peak_val_o), 0);
        chk("mid_rst_ready", int'(ready_o), 0);
        rst_n = 1'b0;
        send_frame(8, 1, 1, 1'b1);
        chk("post_rst_total", int'(total_o), 36);
        chk("post_rst_pbin", int'(peak_bin_o), 7);
        chk("post_rst_err", int'(len_err_o), 0);
        do_read(3, 4);

        // Clear wins over a beat and a read in the same cycle.
        clear_i = 1'b1;
        valid_i = 1'b1;
        din_i = 16'd77;
        rd_en_i = 1'b1;
        rd_addr_i = 3'd2;
        tick();
        clear_i = 1'b0;
        valid_i = 1'b0;
        rd_en_i = 1'b0;
        chk("clr_pri_rdv", int'(rd_valid_o), 0);
        chk("clr_pri_ready", int'(ready_o), 0);
        chk("clr_pri_total", int'(total_o), 0);
        last_i = 1'b1;
        tick();
        last_i = 1'b0;
        chk("clr_pri_ptr_total", int'(total_o), 0);
        chk("clr_pri_ptr_err", int'(len_err_o), 1);
        do_clear();

        // Abort in CAPTURE discards partial frame.
        send_frame(0, 0, 0, 1'b0);
        do_clear();
        din_i = 16'd50;
        valid_i = 1'b1;
        tick();
        tick();
        valid_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        send_frame(8, 5, 0, 1'b0);
        chk("abort_total", int'(total_o), 40);
        chk("abort_err", int'(len_err_o), 0);

        tick();
        tick();
        chk("rq_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
